round_sequencer: RTL and testbench

- Central FSM for the pattern-memory game. Sequences one round at a time: sub-block clear, pattern generation, LED pattern display, button input capture, judge, inter-round gap.
- Counts rounds and correct answers and produces the final score.
- Runs on the 1 kHz game clock between level selection and the 7-segment score display.
- Replaces the ad-hoc delay and loop-reset logic in the game top level.

---
 rtl/round_sequencer.sv | 234 +++++++++++++++++++++++
 tb/tb_round_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/round_sequencer.sv
// ---------------------------------------------------------------------------
// round_sequencer
//
// Central round FSM for the pattern-memory game. Runs on the 1 kHz game
// clock. For each round it clears the sub-blocks, starts the pattern
// generator, the LED display and the input capture in turn, judges the
// result, then waits out an inter-round gap. It counts rounds and correct
// answers and produces the final score once the last round is judged.
//
// Ports:
//   clk           1 kHz game clock
//   rst           synchronous active-high reset, priority over everything
//   start         level chosen, sampled together with level
//   level[2:0]    one-hot level select (001 lv1, 010 lv2, 100 lv3)
//   gen_done      pattern generator finished
//   show_done     pattern display finished
//   inp_done      input trimming finished
//   round_win     compare result, valid while inp_done is high
//   sub_rst       one-cycle clear to generator, display and input blocks
//   gen_start     one-cycle start pulse to the pattern generator
//   show_start    one-cycle start pulse to the display
//   inp_start     one-cycle start pulse to input capture
//   pattern_mask  compare-enable mask per slot, decoded from the level
//   round_count   completed rounds
//   answer_count  correct rounds
//   score         final score, saturating at 127
//   busy          high in every state except IDLE and DONE
//   game_end      high in DONE
//   state         current state encoding, for debug
// ---------------------------------------------------------------------------
module round_sequencer #(
    parameter int NUM_ROUNDS     = 10,
    parameter int GAP_CYCLES     = 500,
    parameter int TIMEOUT_CYCLES = 10000,
    parameter int SCORE_PER_WIN  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  level,
    input  logic        gen_done,
    input  logic        show_done,
    input  logic        inp_done,
    input  logic        round_win,
    output logic        sub_rst,
    output logic        gen_start,
    output logic        show_start,
    output logic        inp_start,
    output logic [15:0] pattern_mask,
    output logic [4:0]  round_count,
    output logic [3:0]  answer_count,
    output logic [6:0]  score,
    output logic        busy,
    output logic        game_end,
    output logic [2:0]  state
);

    // One timer serves both the input timeout and the inter-round gap, so it
    // is sized for whichever of the two is longer.
    localparam int TIMER_MAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
    localparam int TIMER_W   = $clog2(TIMER_MAX + 1);

    localparam logic [TIMER_W-1:0] GAP_LAST     = TIMER_W'(GAP_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [4:0]         LAST_ROUND   = 5'(NUM_ROUNDS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_GEN   = 3'd2,
        S_SHOW  = 3'd3,
        S_INPUT = 3'd4,
        S_JUDGE = 3'd5,
        S_GAP   = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    state_t               cur_state;
    state_t               next_state;
    logic [TIMER_W-1:0]   timer;
    logic                 first_cycle;
    logic                 win_q;
    logic                 level_ok;
    logic                 start_ok;
    logic                 timeout;
    logic [4:0]           round_next;
    logic [3:0]           answer_next;
    logic [31:0]          score_raw;
    logic [6:0]           score_sat;
    logic [15:0]          mask_decoded;

    // A start is only honoured with exactly one level bit set; anything else
    // (000, 011, 111, ...) is treated as if start never arrived.
    always_comb begin
        level_ok = (level == 3'b001) || (level == 3'b010) || (level == 3'b100);
        start_ok = start && level_ok;
    end

    // Compare mask per level: lv1 checks 8 slots, lv2 12 and lv3 all 16.
    always_comb begin
        mask_decoded = 16'hFFFF;
        case (level)
            3'b001:  mask_decoded = 16'h00FF;
            3'b010:  mask_decoded = 16'h0FFF;
            default: mask_decoded = 16'hFFFF;
        endcase
    end

    // Values the JUDGE cycle commits, plus the saturated final score that is
    // loaded on the way into DONE so it is already valid in the first DONE
    // cycle.
    always_comb begin
        timeout     = (timer == TIMEOUT_LAST);
        round_next  = round_count + 5'd1;
        answer_next = answer_count + {3'b000, win_q};
        score_raw   = 32'(SCORE_PER_WIN) * {28'd0, answer_next};
        score_sat   = (score_raw > 32'd127) ? 7'd127 : score_raw[6:0];
    end

    // Next-state logic. Done inputs are only looked at in the state that
    // waits for them, which makes early strobes disappear and a held level
    // advance the FSM at most once per state entry.
    always_comb begin
        next_state = cur_state;
        case (cur_state)
            S_IDLE, S_DONE: begin
                if (start_ok) begin
                    next_state = S_CLEAR;
                end
            end
            S_CLEAR: next_state = S_GEN;
            S_GEN: begin
                if (gen_done) begin
                    next_state = S_SHOW;
                end
            end
            S_SHOW: begin
                if (show_done) begin
                    next_state = S_INPUT;
                end
            end
            S_INPUT: begin
                if (inp_done || timeout) begin
                    next_state = S_JUDGE;
                end
            end
            S_JUDGE: begin
                if (round_next == LAST_ROUND) begin
                    next_state = S_DONE;
                end else begin
                    next_state = S_GAP;
                end
            end
            S_GAP: begin
                if (timer == GAP_LAST) begin
                    next_state = S_CLEAR;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Strobes fire only in the first cycle after a state entry, so a stage
    // that lingers waiting for its done input does not restart its block.
    always_comb begin
        sub_rst    = (cur_state == S_CLEAR);
        gen_start  = (cur_state == S_GEN)   && first_cycle;
        show_start = (cur_state == S_SHOW)  && first_cycle;
        inp_start  = (cur_state == S_INPUT) && first_cycle;
        busy       = (cur_state != S_IDLE) && (cur_state != S_DONE);
        game_end   = (cur_state == S_DONE);
        state      = cur_state;
    end

    // State register and entry bookkeeping. The timer restarts from zero on
    // every state change and only counts where it is actually used.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state   <= S_IDLE;
            first_cycle <= 1'b0;
            timer       <= '0;
        end else begin
            cur_state   <= next_state;
            first_cycle <= (next_state != cur_state);
            if (next_state != cur_state) begin
                timer <= '0;
            end else if ((cur_state == S_INPUT) || (cur_state == S_GAP)) begin
                timer <= timer + 1'b1;
            end
        end
    end

    // Game bookkeeping: level mask, round result, counters and score. A
    // reset in the middle of a round simply drops the round since nothing
    // here is updated before JUDGE.
    always_ff @(posedge clk) begin
        if (rst) begin
            pattern_mask <= '0;
            round_count  <= '0;
            answer_count <= '0;
            score        <= '0;
            win_q        <= 1'b0;
        end else begin
            case (cur_state)
                S_IDLE, S_DONE: begin
                    if (start_ok) begin
                        pattern_mask <= mask_decoded;
                        round_count  <= '0;
                        answer_count <= '0;
                        score        <= '0;
                    end
                end
                S_INPUT: begin
                    // A real answer beats a timeout landing in the same cycle.
                    if (inp_done) begin
                        win_q <= round_win;
                    end else if (timeout) begin
                        win_q <= 1'b0;
                    end
                end
                S_JUDGE: begin
                    round_count  <= round_next;
                    answer_count <= answer_next;
                    if (round_next == LAST_ROUND) begin
                        score <= score_sat;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_round_sequencer.sv
// ---------------------------------------------------------------------------
// tb_round_sequencer
//
// Directed bench for round_sequencer with NUM_ROUNDS=3, GAP_CYCLES=4,
// TIMEOUT_CYCLES=20, SCORE_PER_WIN=10. A scripted responder answers each
// start strobe two cycles later; expected counts and scores are worked out
// by hand for each game.
// ---------------------------------------------------------------------------
module tb_round_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  level;
    logic        gen_done;
    logic        show_done;
    logic        inp_done;
    logic        round_win;
    logic        sub_rst;
    logic        gen_start;
    logic        show_start;
    logic        inp_start;
    logic [15:0] pattern_mask;
    logic [4:0]  round_count;
    logic [3:0]  answer_count;
    logic [6:0]  score;
    logic        busy;
    logic        game_end;
    logic [2:0]  state;

    int checks_total;
    int checks_passed;

    round_sequencer #(
        .NUM_ROUNDS     (3),
        .GAP_CYCLES     (4),
        .TIMEOUT_CYCLES (20),
        .SCORE_PER_WIN  (10)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .level        (level),
        .gen_done     (gen_done),
        .show_done    (show_done),
        .inp_done     (inp_done),
        .round_win    (round_win),
        .sub_rst      (sub_rst),
        .gen_start    (gen_start),
        .show_start   (show_start),
        .inp_start    (inp_start),
        .pattern_mask (pattern_mask),
        .round_count  (round_count),
        .answer_count (answer_count),
        .score        (score),
        .busy         (busy),
        .game_end     (game_end),
        .state        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a game with the given level and check the CLEAR entry.
    task automatic applyStimulus(input logic [2:0] lv, input logic [15:0] exp_mask);
        start = 1'b1;
        level = lv;
        tick();
        start = 1'b0;
        level = 3'b000;
        checkOutput("start_state", 32'(state), 1);
        checkOutput("start_mask", 32'(pattern_mask), 32'(exp_mask));
        checkOutput("start_rounds", 32'(round_count), 0);
        checkOutput("start_answers", 32'(answer_count), 0);
        checkOutput("start_score", 32'(score), 0);
    endtask

    // Plays one round from CLEAR. mode 0: inp_done two cycles after
    // inp_start with round_win=win; mode 1: no inp_done at all (timeout,
    // round_win held high to prove it is ignored); mode 2: inp_done with
    // round_win=1 exactly in the timeout cycle.
    task automatic doRound(input bit win, input int mode, input bit last,
                           input int exp_rounds, input int exp_answers);
        int n;
        checkOutput("clr_state", 32'(state), 1);
        checkOutput("clr_sub_rst", 32'(sub_rst), 1);
        checkOutput("clr_busy", 32'(busy), 1);
        tick();
        checkOutput("gen_state", 32'(state), 2);
        checkOutput("gen_start", 32'(gen_start), 1);
        checkOutput("sub_rst_once", 32'(sub_rst), 0);
        tick();
        checkOutput("gen_start_once", 32'(gen_start), 0);
        tick();
        gen_done = 1'b1;
        tick();
        gen_done = 1'b0;
        checkOutput("show_state", 32'(state), 3);
        checkOutput("show_start", 32'(show_start), 1);
        tick();
        checkOutput("show_start_once", 32'(show_start), 0);
        tick();
        show_done = 1'b1;
        tick();
        show_done = 1'b0;
        checkOutput("input_state", 32'(state), 4);
        checkOutput("inp_start", 32'(inp_start), 1);
        if (mode == 1) begin
            round_win = 1'b1;
            n = 0;
            while (state == 3'd4 && n < 100) begin
                n++;
                tick();
            end
            round_win = 1'b0;
            checkOutput("timeout_len", 32'(n), 20);
        end else if (mode == 2) begin
            repeat (19) tick();
            checkOutput("pre_timeout_state", 32'(state), 4);
            inp_done  = 1'b1;
            round_win = 1'b1;
            tick();
            inp_done  = 1'b0;
            round_win = 1'b0;
        end else begin
            tick();
            checkOutput("inp_start_once", 32'(inp_start), 0);
            tick();
            inp_done  = 1'b1;
            round_win = win;
            tick();
            inp_done  = 1'b0;
            round_win = 1'b0;
        end
        checkOutput("judge_state", 32'(state), 5);
        tick();
        checkOutput("rounds", 32'(round_count), 32'(exp_rounds));
        checkOutput("answers", 32'(answer_count), 32'(exp_answers));
        if (last) begin
            checkOutput("done_state", 32'(state), 7);
            checkOutput("done_game_end", 32'(game_end), 1);
            checkOutput("done_busy", 32'(busy), 0);
        end else begin
            n = 0;
            while (state == 3'd6 && n < 50) begin
                n++;
                if (n == 2) begin
                    gen_done  = 1'b1;
                    show_done = 1'b1;
                    inp_done  = 1'b1;
                end else begin
                    gen_done  = 1'b0;
                    show_done = 1'b0;
                    inp_done  = 1'b0;
                end
                tick();
            end
            gen_done  = 1'b0;
            show_done = 1'b0;
            inp_done  = 1'b0;
            checkOutput("gap_len", 32'(n), 4);
        end
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        rst       = 1'b1;
        start     = 1'b0;
        level     = 3'b000;
        gen_done  = 1'b0;
        show_done = 1'b0;
        inp_done  = 1'b0;
        round_win = 1'b0;
        repeat (3) tick();
        checkOutput("rst_state", 32'(state), 0);
        checkOutput("rst_mask", 32'(pattern_mask), 0);
        checkOutput("rst_outputs", 32'({sub_rst, gen_start, show_start, inp_start, busy, game_end}), 0);
        checkOutput("rst_counts", 32'({round_count, answer_count, score}), 0);
        rst = 1'b0;
        tick();

        $display("[TB] non-one-hot start");
        start = 1'b1;
        level = 3'b011;
        tick();
        checkOutput("bad_level_011", 32'(state), 0);
        level = 3'b000;
        tick();
        start = 1'b0;
        checkOutput("bad_level_000", 32'(state), 0);
        checkOutput("bad_level_mask", 32'(pattern_mask), 0);

        $display("[TB] game 1: lv2, wins 1 1 1");
        applyStimulus(3'b010, 16'h0FFF);
        doRound(1'b1, 0, 1'b0, 1, 1);
        doRound(1'b1, 0, 1'b0, 2, 2);
        doRound(1'b1, 0, 1'b1, 3, 3);
        checkOutput("g1_score", 32'(score), 30);
        repeat (3) tick();
        checkOutput("g1_hold_state", 32'(state), 7);
        checkOutput("g1_hold_mask", 32'(pattern_mask), 32'h0FFF);
        checkOutput("g1_hold_score", 32'(score), 30);

        $display("[TB] game 2: lv1, wins 1 0 1");
        applyStimulus(3'b001, 16'h00FF);
        doRound(1'b1, 0, 1'b0, 1, 1);
        doRound(1'b0, 0, 1'b0, 2, 1);
        doRound(1'b1, 0, 1'b1, 3, 2);
        checkOutput("g2_score", 32'(score), 20);

        $display("[TB] game 3: lv2, round 2 times out");
        applyStimulus(3'b010, 16'h0FFF);
        doRound(1'b1, 0, 1'b0, 1, 1);
        doRound(1'b0, 1, 1'b0, 2, 1);
        doRound(1'b1, 0, 1'b1, 3, 2);
        checkOutput("g3_score", 32'(score), 20);

        $display("[TB] game 4: lv3 restart, inp_done in timeout cycle");
        applyStimulus(3'b100, 16'hFFFF);
        doRound(1'b0, 0, 1'b0, 1, 0);
        doRound(1'b0, 2, 1'b0, 2, 1);
        doRound(1'b0, 0, 1'b1, 3, 1);
        checkOutput("g4_score", 32'(score), 10);

        $display("[TB] stray events while busy");
        applyStimulus(3'b010, 16'h0FFF);
        tick();
        checkOutput("stray_gen_entry", 32'(state), 2);
        tick();
        show_done = 1'b1;
        start     = 1'b1;
        level     = 3'b100;
        tick();
        show_done = 1'b0;
        start     = 1'b0;
        level     = 3'b000;
        checkOutput("stray_gen_state", 32'(state), 2);
        checkOutput("stray_gen_strobes", 32'({sub_rst, gen_start, show_start, inp_start}), 0);
        checkOutput("stray_gen_mask", 32'(pattern_mask), 32'h0FFF);
        gen_done = 1'b1;
        tick();
        gen_done = 1'b0;
        checkOutput("stray_show_entry", 32'(state), 3);
        tick();
        start = 1'b1;
        level = 3'b001;
        tick();
        start = 1'b0;
        level = 3'b000;
        checkOutput("stray_show_state", 32'(state), 3);
        checkOutput("stray_show_strobes", 32'({sub_rst, gen_start, show_start, inp_start}), 0);
        checkOutput("stray_show_counts", 32'({round_count, answer_count}), 0);
        checkOutput("stray_show_mask", 32'(pattern_mask), 32'h0FFF);

        $display("[TB] reset mid-input of round 2");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        applyStimulus(3'b100, 16'hFFFF);
        doRound(1'b1, 0, 1'b0, 1, 1);
        tick();
        gen_done = 1'b1;
        tick();
        gen_done  = 1'b0;
        show_done = 1'b1;
        tick();
        show_done = 1'b0;
        checkOutput("abort_pre_state", 32'(state), 4);
        tick();
        rst      = 1'b1;
        inp_done = 1'b1;
        round_win = 1'b1;
        tick();
        rst       = 1'b0;
        inp_done  = 1'b0;
        round_win = 1'b0;
        checkOutput("abort_state", 32'(state), 0);
        checkOutput("abort_mask", 32'(pattern_mask), 0);
        checkOutput("abort_counts", 32'({round_count, answer_count, score}), 0);
        checkOutput("abort_outputs", 32'({sub_rst, gen_start, show_start, inp_start, busy, game_end}), 0);

        $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
